// File: rtl/cnt_cmd_seq_pkg.sv
// cnt_cmd_pkg: shared types and defaults for the counter command sequencer.
//   cmd_op_e    - command opcodes carried on the command bus
//   seq_state_e - sequencer FSM states
//   CNT_WIDTH / CNT_LEN_W - default counter data width and run-length width
package cnt_cmd_pkg;

    localparam int unsigned CNT_WIDTH = 16;
    localparam int unsigned CNT_LEN_W = 8;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_LOAD = 2'b01,
        CMD_UP   = 2'b10,
        CMD_DOWN = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } seq_state_e;

    // UP and DOWN are the only opcodes that carry a run length.
    function automatic logic is_count_op(input cmd_op_e op);
        return (op == CMD_UP) || (op == CMD_DOWN);
    endfunction

endpackage

// File: rtl/cnt_cmd_seq_if.sv
// cnt_cmd_seq_if: valid/ready command bus into the counter sequencer.
//   cmd_valid - command present (source)
//   cmd_ready - sequencer can accept (sink)
//   cmd_op    - opcode: 00 NOP, 01 LOAD, 10 UP, 11 DOWN (source)
//   cmd_data  - LOAD value (source)
//   cmd_len   - UP/DOWN enabled-cycle count (source)
// Modports: master = command source, slave = sequencer.
interface cnt_cmd_seq_if
    import cnt_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH,
    parameter int unsigned LEN_W = CNT_LEN_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/cnt_cmd_seq.sv
// cnt_cmd_seq: command sequencer driving the control inputs of a 16-bit
// up/down counter. Accepts LOAD / UP n / DOWN n / NOP commands and turns
// them into ld_cnt / count_enb / updn_cnt / data_in activity.
// Ports:
//   clk       - system clock, rising edge
//   rst_      - asynchronous active-low reset
//   cmd       - command bus (slave modport of cnt_cmd_seq_if)
//   hold      - pauses an UP/DOWN run; ignored elsewhere
//   data_in   - counter load value (holds last loaded value)
//   ld_cnt    - counter load strobe, one cycle per LOAD
//   updn_cnt  - counter direction, 1 = up (holds last direction)
//   count_enb - counter enable, high on RUN cycles without hold
//   busy      - a command is in progress
//   done      - one-cycle registered completion pulse
module cnt_cmd_seq
    import cnt_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH,
    parameter int unsigned LEN_W = CNT_LEN_W
) (
    input  logic             clk,
    input  logic             rst_,
    cnt_cmd_seq_if.slave     cmd,
    input  logic             hold,
    output logic [WIDTH-1:0] data_in,
    output logic             ld_cnt,
    output logic             updn_cnt,
    output logic             count_enb,
    output logic             busy,
    output logic             done
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             updn_q,  updn_d;
    logic [LEN_W-1:0] rem_q,   rem_d;
    logic             done_q,  done_d;

    logic             accept;
    cmd_op_e          op;

    assign op     = cmd_op_e'(cmd.cmd_op);
    assign accept = cmd.cmd_valid && (state_q == S_IDLE);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            updn_q  <= 1'b0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            updn_q  <= updn_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        updn_d  = updn_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == CMD_LOAD) begin
                        data_d  = cmd.cmd_data;
                        state_d = S_LOAD;
                    end else if (is_count_op(op) && (cmd.cmd_len != '0)) begin
                        updn_d  = (op == CMD_UP);
                        rem_d   = cmd.cmd_len;
                        state_d = S_RUN;
                    end else begin
                        // NOP or zero-length run: complete without touching
                        // the counter controls.
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_RUN: begin
                // Hold freezes the remaining count, so paused cycles are
                // inserted without losing enabled cycles.
                if (!hold) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign data_in       = data_q;
    assign updn_cnt      = updn_q;
    assign ld_cnt        = (state_q == S_LOAD);
    assign count_enb     = (state_q == S_RUN) && !hold;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule
